// File: rtl/urp_pcie_dll_replay_tx_if.sv
// TLP ingress, link frame egress and DLLP return channel of the TX data link layer.
// master: the replay block itself; slave: the transaction layer / link environment.
interface urp_pcie_dll_replay_tx_if #(
  parameter int unsigned TLP_W = 256,
  parameter int unsigned SEQ_W = 12
);
  logic [TLP_W-1:0]       tlp;
  logic                   tlp_valid;
  logic                   tlp_ready;
  logic [SEQ_W+TLP_W-1:0] tx_tlp_data;
  logic                   tx_tlp_valid;
  logic                   tx_tlp_ready;
  logic [31:0]            dllp;
  logic                   dllp_valid;
  logic                   dllp_ready;

  modport master (
    input  tlp, tlp_valid, tx_tlp_ready, dllp, dllp_valid,
    output tlp_ready, tx_tlp_data, tx_tlp_valid, dllp_ready
  );

  modport slave (
    output tlp, tlp_valid, tx_tlp_ready, dllp, dllp_valid,
    input  tlp_ready, tx_tlp_data, tx_tlp_valid, dllp_ready
  );
endinterface

// File: rtl/urp_pcie_dll_replay_tx.sv
// TX data link layer: sequence-tags TLPs, holds them in a replay buffer until ACKed and
// retransmits from the oldest unacked entry on NAK or replay timeout.
module urp_pcie_dll_replay_tx #(
  parameter int unsigned TLP_W          = 256,
  parameter int unsigned SEQ_W          = 12,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned REPLAY_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  urp_pcie_dll_replay_tx_if.master    bus,
  output logic [$clog2(DEPTH):0]      buf_count_o,
  output logic [SEQ_W-1:0]            next_seq_o,
  output logic [SEQ_W-1:0]            acked_seq_o,
  output logic [1:0]                  replay_num_o,
  output logic                        replay_rollover_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned TmrW = $clog2(REPLAY_TIMEOUT) + 1;
  localparam logic [7:0]  TypeAck = 8'h00;
  localparam logic [7:0]  TypeNak = 8'h10;

  typedef enum logic [0:0] {StNormal, StReplay} state_e;

  state_e                 state_q, state_d;
  logic [SEQ_W-1:0]       nts_q, nts_d, as_q, as_d, send_q, send_d;
  logic [TmrW-1:0]        timer_q, timer_d;
  logic [1:0]             num_q, num_d;
  logic                   roll_q, roll_d, pend_q, pend_d;
  logic [SEQ_W+TLP_W-1:0] mem [DEPTH];

  logic [SEQ_W-1:0] count, count_new, as_new, seq_off, dllp_seq, send_adv;
  logic             tx_valid, beat_done, beat_hold, accept, tlp_ready;
  logic             is_ack, is_nak, seq_ok, purge, timeout, replay_req, replay_go;
  logic [1:0]       num_base;
  logic             unused_dllp;

  assign unused_dllp = ^bus.dllp[23:12];

  // Common decode shared by next-state and output logic
  always_comb begin
    count      = nts_q - as_q - 1'b1;
    tx_valid   = (send_q != nts_q);
    beat_done  = tx_valid && bus.tx_tlp_ready;
    beat_hold  = tx_valid && !bus.tx_tlp_ready;
    tlp_ready  = (state_q == StNormal) && (count != SEQ_W'(DEPTH));
    accept     = bus.tlp_valid && tlp_ready;
    dllp_seq   = bus.dllp[SEQ_W-1:0];
    is_ack     = bus.dllp_valid && (bus.dllp[31:24] == TypeAck);
    is_nak     = bus.dllp_valid && (bus.dllp[31:24] == TypeNak);
    seq_off    = dllp_seq - as_q;
    seq_ok     = (seq_off != '0) && (seq_off <= count);
    purge      = (is_ack || is_nak) && seq_ok;
    as_new     = purge ? dllp_seq : as_q;
    count_new  = nts_q - as_new - 1'b1;
    timeout    = (count != '0) && (timer_q == TmrW'(REPLAY_TIMEOUT - 1));
    replay_req = pend_q || is_nak || timeout;
    // A replay with nothing left after the purge is dropped; a stalled beat defers the rewind
    replay_go  = replay_req && !beat_hold && (count_new != '0);
  end

  // Datapath next state
  always_comb begin
    nts_d    = nts_q + SEQ_W'(accept);
    as_d     = as_new;
    pend_d   = replay_req && beat_hold;
    send_adv = send_q + SEQ_W'(beat_done);
    send_d   = send_adv;
    if (replay_go) begin
      send_d = as_new + 1'b1;
    end else if (!beat_hold && ((send_adv - as_new - 1'b1) > count_new)) begin
      // ACK purged past the send pointer: skip frames the receiver already has
      send_d = as_new + 1'b1;
    end
    timer_d = '0;
    if (!purge && !replay_go && (count != '0)) begin
      timer_d = timer_q + 1'b1;
    end
    num_base = purge ? 2'd0 : num_q;
    num_d    = replay_go ? num_base + 2'd1 : num_base;
    roll_d   = replay_go && (num_base == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    if (replay_go) begin
      state_d = StReplay;
    end else if ((state_q == StReplay) && (send_d == nts_q)) begin
      state_d = StNormal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StNormal;
      nts_q   <= '0;
      as_q    <= '1;
      send_q  <= '0;
      timer_q <= '0;
      num_q   <= '0;
      roll_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nts_q   <= nts_d;
      as_q    <= as_d;
      send_q  <= send_d;
      timer_q <= timer_d;
      num_q   <= num_d;
      roll_q  <= roll_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[nts_q[IdxW-1:0]] <= {nts_q, bus.tlp};
    end
  end

  always_comb begin
    bus.tlp_ready     = tlp_ready;
    bus.tx_tlp_valid  = tx_valid;
    bus.tx_tlp_data   = tx_valid ? mem[send_q[IdxW-1:0]] : '0;
    bus.dllp_ready    = 1'b1;
    buf_count_o       = count[IdxW:0];
    next_seq_o        = nts_q;
    acked_seq_o       = as_q;
    replay_num_o      = num_q;
    replay_rollover_o = roll_q;
  end

endmodule

// File: tb/tb_urp_pcie_dll_replay_tx.sv
// Directed bench for the TX replay block: ordering, backpressure, NAK/timeout replay, wrap, reset.
module tb_urp_pcie_dll_replay_tx;
  localparam logic [7:0] ACK = 8'h00;
  localparam logic [7:0] NAK = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  buf_count;
  logic [11:0] next_seq, acked_seq;
  logic [1:0]  replay_num;
  logic        replay_rollover;
  int          total = 0, passed = 0, cyc = 0;
  logic [267:0] frames[$];

  urp_pcie_dll_replay_tx_if #(.TLP_W(256), .SEQ_W(12)) bus ();

  urp_pcie_dll_replay_tx #(
    .TLP_W(256), .SEQ_W(12), .DEPTH(8), .REPLAY_TIMEOUT(64)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus.master),
    .buf_count_o       (buf_count),
    .next_seq_o        (next_seq),
    .acked_seq_o       (acked_seq),
    .replay_num_o      (replay_num),
    .replay_rollover_o (replay_rollover)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && bus.tx_tlp_valid && bus.tx_tlp_ready) frames.push_back(bus.tx_tlp_data);

  function automatic logic [255:0] mk(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hC3A5_0000;
    return {8{w}};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    bus.tlp = '0; bus.tlp_valid = 0; bus.tx_tlp_ready = 1; bus.dllp = '0; bus.dllp_valid = 0;
    rst_n = 0;
    tick(2);
    rst_n = 1;
    frames.delete();
  endtask

  task automatic send_tlp(input logic [255:0] d);
    int n = 0;
    bus.tlp = d; bus.tlp_valid = 1;
    while (!bus.tlp_ready && n < 50) begin tick(1); n++; end
    if (!bus.tlp_ready) begin
      total++; $display("FAIL send_tlp: tlp_ready stuck at 0 after %0d cycles, want 1", n);
    end
    tick(1);
    bus.tlp_valid = 0;
  endtask

  task automatic send_dllp(input logic [7:0] t, input logic [11:0] s);
    bus.dllp = {t, 12'h000, s}; bus.dllp_valid = 1;
    tick(1);
    bus.dllp_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bus.tlp_ready !== 1'b1) $display("FAIL rst_tlp_ready: got %b want 1", bus.tlp_ready); else passed++;
    total++; if (bus.tx_tlp_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", bus.tx_tlp_valid); else passed++;
    total++; if (bus.tx_tlp_data !== 268'd0) $display("FAIL rst_tx_data: got %h want 0", bus.tx_tlp_data); else passed++;
    total++; if (bus.dllp_ready !== 1'b1) $display("FAIL rst_dllp_ready: got %b want 1", bus.dllp_ready); else passed++;
    total++; if (buf_count !== 4'd0) $display("FAIL rst_buf_count: got %0d want 0", buf_count); else passed++;
    total++; if (next_seq !== 12'd0) $display("FAIL rst_next_seq: got %h want 0", next_seq); else passed++;
    total++; if (acked_seq !== 12'hFFF) $display("FAIL rst_acked_seq: got %h want fff", acked_seq); else passed++;
    total++; if (replay_num !== 2'd0) $display("FAIL rst_replay_num: got %0d want 0", replay_num); else passed++;
    total++; if (replay_rollover !== 1'b0) $display("FAIL rst_rollover: got %b want 0", replay_rollover); else passed++;
  endtask

  task automatic test_in_order();
    apply_reset();
    for (int i = 0; i < 3; i++) send_tlp(mk(i));
    tick(3);
    total++; if (frames.size() != 3) $display("FAIL order_count: got %0d frames want 3", frames.size()); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (frames[k] !== {12'(k), mk(k)}) $display("FAIL order_frame%0d: got %h want %h", k, frames[k], {12'(k), mk(k)});
      else passed++;
    end
    send_dllp(ACK, 12'd1);
    total++; if (buf_count !== 4'd1) $display("FAIL ack1_count: got %0d want 1", buf_count); else passed++;
    total++; if (acked_seq !== 12'd1) $display("FAIL ack1_as: got %0d want 1", acked_seq); else passed++;
  endtask

  task automatic test_full();
    int acc = 0;
    logic hs;
    apply_reset();
    bus.tx_tlp_ready = 0;
    bus.tlp_valid = 1;
    for (int k = 0; k < 12; k++) begin
      bus.tlp = mk(acc); hs = bus.tlp_ready;
      tick(1);
      if (hs) acc++;
    end
    bus.tlp_valid = 0;
    total++; if (acc != 8) $display("FAIL full_accepted: got %0d want 8", acc); else passed++;
    total++; if (bus.tlp_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.tlp_ready); else passed++;
    total++; if (buf_count !== 4'd8) $display("FAIL full_count: got %0d want 8", buf_count); else passed++;
    total++; if (bus.tx_tlp_data !== {12'd0, mk(0)}) $display("FAIL full_held: got %h want seq 0 frame", bus.tx_tlp_data); else passed++;
    send_dllp(ACK, 12'd7);
    total++; if (bus.tlp_ready !== 1'b1) $display("FAIL ack7_ready: got %b want 1", bus.tlp_ready); else passed++;
    total++; if (buf_count !== 4'd0) $display("FAIL ack7_count: got %0d want 0", buf_count); else passed++;
    bus.tx_tlp_ready = 1;
    tick(3);
    total++; if (bus.tx_tlp_valid !== 1'b0) $display("FAIL ack7_drain: got valid %b want 0", bus.tx_tlp_valid); else passed++;
  endtask

  task automatic test_nak();
    apply_reset();
    for (int i = 0; i < 4; i++) send_tlp(mk(i));
    tick(3);
    frames.delete();
    send_dllp(NAK, 12'd0);
    total++; if (acked_seq !== 12'd0) $display("FAIL nak_as: got %0d want 0", acked_seq); else passed++;
    total++; if (replay_num !== 2'd1) $display("FAIL nak_num: got %0d want 1", replay_num); else passed++;
    total++; if (bus.tlp_ready !== 1'b0) $display("FAIL nak_block: got %b want 0", bus.tlp_ready); else passed++;
    tick(5);
    total++; if (frames.size() != 3) $display("FAIL nak_count: got %0d frames want 3", frames.size()); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (frames[k] !== {12'(k + 1), mk(k + 1)}) $display("FAIL nak_frame%0d: got %h want %h", k, frames[k], {12'(k + 1), mk(k + 1)});
      else passed++;
    end
    total++; if (bus.tlp_ready !== 1'b1) $display("FAIL nak_resume: got %b want 1", bus.tlp_ready); else passed++;
  endtask

  task automatic test_timeout();
    int t0, t1, n;
    apply_reset();
    send_tlp(mk(0));
    t0 = cyc;
    send_tlp(mk(1));
    n = 0;
    while (replay_num != 2'd1 && n < 200) begin tick(1); n++; end
    total++; if (cyc - t0 != 64) $display("FAIL timeout_first: replay after %0d cycles want 64", cyc - t0); else passed++;
    t1 = cyc; n = 0;
    while (replay_rollover !== 1'b1 && n < 400) begin tick(1); n++; end
    total++; if (cyc - t1 != 192) $display("FAIL timeout_roll: rollover after %0d cycles want 192", cyc - t1); else passed++;
    total++; if (replay_num !== 2'd0) $display("FAIL timeout_wrap: got %0d want 0", replay_num); else passed++;
    tick(1);
    total++; if (replay_rollover !== 1'b0) $display("FAIL timeout_pulse: got %b want 0", replay_rollover); else passed++;
  endtask

  task automatic test_stale_and_hold();
    apply_reset();
    for (int i = 0; i < 3; i++) send_tlp(mk(i));
    tick(2);
    send_dllp(ACK, 12'd0);
    send_dllp(ACK, 12'd0);
    total++; if (acked_seq !== 12'd0 || buf_count !== 4'd2) $display("FAIL stale_ack: got as=%0d cnt=%0d want 0/2", acked_seq, buf_count); else passed++;
    send_dllp(ACK, 12'd5);
    total++; if (acked_seq !== 12'd0 || buf_count !== 4'd2) $display("FAIL beyond_ack: got as=%0d cnt=%0d want 0/2", acked_seq, buf_count); else passed++;
    send_dllp(8'h20, 12'd2);
    total++; if (acked_seq !== 12'd0) $display("FAIL bad_type: got as=%0d want 0", acked_seq); else passed++;
    frames.delete();
    bus.tx_tlp_ready = 0;
    send_tlp(mk(3));
    send_dllp(NAK, 12'd1);
    total++; if (acked_seq !== 12'd1) $display("FAIL hold_as: got %0d want 1", acked_seq); else passed++;
    tick(3);
    total++; if (bus.tx_tlp_valid !== 1'b1 || bus.tx_tlp_data !== {12'd3, mk(3)}) $display("FAIL hold_beat: got v=%b d=%h want seq 3 frame", bus.tx_tlp_valid, bus.tx_tlp_data); else passed++;
    total++; if (replay_num !== 2'd0) $display("FAIL hold_num: got %0d want 0", replay_num); else passed++;
    bus.tx_tlp_ready = 1;
    tick(4);
    total++; if (frames.size() != 3) $display("FAIL rewind_count: got %0d frames want 3", frames.size()); else passed++;
    total++; if (frames[0] !== {12'd3, mk(3)} || frames[1] !== {12'd2, mk(2)} || frames[2] !== {12'd3, mk(3)})
      $display("FAIL rewind_order: got %h %h %h want seq 3,2,3", frames[0][267:256], frames[1][267:256], frames[2][267:256]);
    else passed++;
    total++; if (replay_num !== 2'd1) $display("FAIL rewind_num: got %0d want 1", replay_num); else passed++;
  endtask

  task automatic test_wrap_and_reset();
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 4100; i++) begin
      send_tlp(mk(i));
      if (i % 4 == 3) begin tick(2); send_dllp(ACK, 12'(i)); end
    end
    tick(2);
    total++; if (frames.size() != 4100) $display("FAIL wrap_count: got %0d frames want 4100", frames.size()); else passed++;
    foreach (frames[k]) if (frames[k] !== {12'(k), mk(k)}) bad++;
    total++; if (bad != 0) $display("FAIL wrap_frames: got %0d bad frames want 0", bad); else passed++;
    total++; if (next_seq !== 12'd4 || acked_seq !== 12'd3 || buf_count !== 4'd0)
      $display("FAIL wrap_state: got nts=%0d as=%0d cnt=%0d want 4/3/0", next_seq, acked_seq, buf_count);
    else passed++;
    for (int i = 4; i < 7; i++) send_tlp(mk(i));
    tick(2);
    bus.tx_tlp_ready = 0;
    send_dllp(NAK, 12'd4);
    total++; if (bus.tlp_ready !== 1'b0 || replay_num !== 2'd1 || bus.tx_tlp_valid !== 1'b1)
      $display("FAIL midreplay: got rdy=%b num=%0d v=%b want 0/1/1", bus.tlp_ready, replay_num, bus.tx_tlp_valid);
    else passed++;
    rst_n = 0;
    tick(1);
    total++; if (bus.tlp_ready !== 1'b1 || bus.tx_tlp_valid !== 1'b0 || bus.tx_tlp_data !== 268'd0)
      $display("FAIL rst_io: got rdy=%b v=%b d=%h want 1/0/0", bus.tlp_ready, bus.tx_tlp_valid, bus.tx_tlp_data);
    else passed++;
    total++; if (buf_count !== 4'd0 || next_seq !== 12'd0 || acked_seq !== 12'hFFF || replay_num !== 2'd0)
      $display("FAIL rst_state: got cnt=%0d nts=%0d as=%h num=%0d want 0/0/fff/0", buf_count, next_seq, acked_seq, replay_num);
    else passed++;
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_nak();
    test_timeout();
    test_stale_and_hold();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
